// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module  : seq_det_pkg
// Brief   : Shared constants, FSM encoding and width helper for seq_detector_param
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

   localparam int         c_def_pat_w   = 8;
   localparam int         c_def_cnt_w   = 8;
   localparam logic [7:0] c_def_rst_pat = 8'b0000_0110;
   localparam int         c_def_rst_len = 5;
   localparam logic       c_def_rst_ovl = 1'b1;

   typedef enum logic [0:0] {
      ST_DISABLED = 1'b0,
      ST_RUN      = 1'b1
   } det_state_t;

   // Length fields must hold 0..PAT_W inclusive.
   function automatic int len_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter with clear; clear plus increment yields 1
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   logic [CNT_W-1:0] r_count;
   logic             w_full;

   assign w_full = &r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= inc ? CNT_W'(1) : '0;
      end else if (inc && !w_full) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;
   assign sat   = w_full;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module  : seq_detector_param
// Brief   : Runtime-programmable serial pattern detector with Mealy match,
//           registered match and saturating match counter
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int             PAT_W   = c_def_pat_w,
   parameter int             CNT_W   = c_def_cnt_w,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(c_def_rst_pat),
   parameter int             RST_LEN = c_def_rst_len,
   parameter logic           RST_OVL = c_def_rst_ovl,
   localparam int            LEN_W   = len_w(PAT_W)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             count_clr,
   output logic             out,
   output logic             out_q,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam logic [LEN_W-1:0] c_rst_len =
      (RST_LEN > PAT_W) ? LEN_W'(PAT_W) : LEN_W'(RST_LEN);

   det_state_t       r_state;
   logic [PAT_W-1:0] r_pat;
   logic [LEN_W-1:0] r_len;
   logic             r_ovl;
   logic [PAT_W-2:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic             r_out_q;

   logic [PAT_W-1:0] w_window;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W:0]   w_fill_p1;
   logic             w_fill_ok;
   logic             w_eq;
   logic             w_out;
   logic [LEN_W-1:0] w_len_cl;

   assign w_window  = {r_hist, in};
   assign w_fill_p1 = {1'b0, r_fill} + (LEN_W+1)'(1);
   // fill >= len-1, evaluated without wrap when len is small
   assign w_fill_ok = (w_fill_p1 >= {1'b0, r_len});
   assign w_len_cl  = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (LEN_W'(i) < r_len);
      end
   end

   assign w_eq  = (((w_window ^ r_pat) & w_mask) == '0);
   assign w_out = (r_state == ST_RUN) & in_valid & ~cfg_load & ~rst & w_fill_ok & w_eq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= (c_rst_len == '0) ? ST_DISABLED : ST_RUN;
         r_pat   <= RST_PAT;
         r_len   <= c_rst_len;
         r_ovl   <= RST_OVL;
         r_hist  <= '0;
         r_fill  <= '0;
         r_out_q <= 1'b0;
      end else begin
         r_out_q <= w_out;
         if (cfg_load) begin
            r_state <= (w_len_cl == '0) ? ST_DISABLED : ST_RUN;
            r_pat   <= cfg_pattern;
            r_len   <= w_len_cl;
            r_ovl   <= cfg_overlap;
            r_fill  <= '0;
         end else if (r_state == ST_RUN && in_valid) begin
            if (w_out && !r_ovl) begin
               r_fill <= '0;
            end else begin
               r_hist <= w_window[PAT_W-2:0];
               if (!w_fill_ok) begin
                  r_fill <= r_fill + LEN_W'(1);
               end
            end
         end
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_out),
      .clr   (count_clr),
      .count (match_count),
      .sat   (count_sat)
   );

   assign out   = w_out;
   assign out_q = r_out_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module  : tb_seq_detector_param
// Brief   : Directed self-checking bench for seq_detector_param with a
//           queue-based reference model checked on every falling edge
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in = 1'b0;
   logic       in_valid = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = 8'h00;
   logic [3:0] cfg_len = 4'd0;
   logic       cfg_overlap = 1'b0;
   logic       count_clr = 1'b0;
   logic       out;
   logic       out_q;
   logic [7:0] match_count;
   logic       count_sat;

   int n_cmp  = 0;
   int n_bad  = 0;
   int pulses = 0;

   seq_detector_param #(
      .PAT_W   (8),
      .CNT_W   (8),
      .RST_PAT (8'b0000_0110),
      .RST_LEN (5),
      .RST_OVL (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in          (in),
      .in_valid    (in_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .count_clr   (count_clr),
      .out         (out),
      .out_q       (out_q),
      .match_count (match_count),
      .count_sat   (count_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: every valid bit since the last flush, oldest first.
   int         m_hist[$];
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   int         m_cnt;
   bit         m_outq;

   task automatic model_reset();
      m_hist.delete();
      m_pat  = 8'b0000_0110;
      m_len  = 5;
      m_ovl  = 1'b1;
      m_cnt  = 0;
      m_outq = 1'b0;
   endtask

   function automatic bit model_out();
      int b;
      if (rst || cfg_load || !in_valid || m_len == 0) return 1'b0;
      if (m_hist.size() < m_len - 1) return 1'b0;
      for (int k = 0; k < m_len; k++) begin
         b = (k == 0) ? int'(in) : m_hist[m_hist.size() - k];
         if (b != int'(m_pat[k])) return 1'b0;
      end
      return 1'b1;
   endfunction

   initial begin : compare
      bit e;
      model_reset();
      forever begin
         @(negedge clk or posedge rst);
         if (rst) begin
            #1;
            model_reset();
            chk("rst_out", out, 0);
            chk("rst_out_q", out_q, 0);
            chk("rst_count", match_count, 0);
            chk("rst_sat", count_sat, 0);
         end else begin
            e = model_out();
            chk("out", out, e);
            chk("out_q", out_q, m_outq);
            chk("count", match_count, m_cnt);
            chk("sat", count_sat, (m_cnt == 255));
            if (count_clr)               m_cnt = e ? 1 : 0;
            else if (e && m_cnt < 255)   m_cnt++;
            m_outq = e;
            if (cfg_load) begin
               m_pat = cfg_pattern;
               m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
               m_ovl = cfg_overlap;
               m_hist.delete();
            end else if (in_valid && m_len > 0) begin
               if (e && !m_ovl) m_hist.delete();
               else begin
                  m_hist.push_back(int'(in));
                  if (m_hist.size() > 8) void'(m_hist.pop_front());
               end
            end
         end
      end
   end

   task automatic step(input bit b, input bit v, input bit clr = 1'b0);
      @(posedge clk); #1;
      in = b; in_valid = v; count_clr = clr; cfg_load = 1'b0;
      @(negedge clk); #1;
      if (out === 1'b1) pulses++;
   endtask

   task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
      @(posedge clk); #1;
      cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
      count_clr = 1'b1; in = 1'b1; in_valid = 1'b1;
      @(negedge clk); #1;
      chk("load_out", out, 0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      logic [4:0]  s5;
      logic [15:0] s16;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Default 00110 with overlap
      pulses = 0; s5 = 5'b00110;
      for (int i = 4; i >= 0; i--) begin
         step(s5[i], 1'b1);
         if (i == 0) chk("t1_out_bit5", out, 1);
         else        chk("t1_out_early", out, 0);
      end
      step(1'b0, 1'b0);
      chk("t1_out_q", out_q, 1);
      chk("t1_count", match_count, 1);
      chk("t1_pulses", pulses, 1);
      chk("t1_model_cnt", m_cnt, 1);

      // 101 overlapping
      load(8'b101, 4'd3, 1'b1);
      pulses = 0; s5 = 5'b10101;
      for (int i = 4; i >= 0; i--) step(s5[i], 1'b1);
      step(1'b0, 1'b0);
      chk("t2_ovl_pulses", pulses, 2);
      chk("t2_ovl_count", match_count, 2);

      // 101 non-overlapping
      load(8'b101, 4'd3, 1'b0);
      pulses = 0;
      for (int i = 4; i >= 0; i--) step(s5[i], 1'b1);
      step(1'b0, 1'b0);
      chk("t2_novl_pulses", pulses, 1);
      chk("t2_novl_count", match_count, 1);
      chk("t2_model_cnt", m_cnt, 1);

      // Gaps between valid bits with in toggling
      load(8'b0000_0110, 4'd5, 1'b1);
      pulses = 0; s5 = 5'b00110;
      for (int i = 4; i >= 0; i--) begin
         step(s5[i], 1'b1);
         step(~s5[i], 1'b0);
         step(s5[i], 1'b0);
      end
      step(1'b0, 1'b0);
      chk("t3_pulses", pulses, 1);
      chk("t3_count", match_count, 1);

      // Reset mid-pattern
      s5 = 5'b00110;
      for (int i = 4; i >= 1; i--) step(s5[i], 1'b1);
      @(posedge clk); #1 in_valid = 1'b0;
      #1 rst = 1'b1;
      #1 chk("t4_count_now", match_count, 0);
      chk("t4_out_q_now", out_q, 0);
      #1 rst = 1'b0;
      pulses = 0;
      step(1'b0, 1'b1);
      chk("t4_no_match", pulses, 0);

      // Saturation with 1-bit pattern
      load(8'h01, 4'd1, 1'b1);
      pulses = 0;
      repeat (300) step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      chk("t5_pulses", pulses, 300);
      chk("t5_count", match_count, 255);
      chk("t5_sat", count_sat, 1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0);
      chk("t5_clr_match", match_count, 1);
      chk("t5_sat_clr", count_sat, 0);

      // Length 0 disables detection
      load(8'h00, 4'd0, 1'b1);
      pulses = 0; s16 = 16'hA5F0;
      for (int i = 15; i >= 0; i--) step(s16[i], 1'b1);
      step(1'b0, 1'b0);
      chk("t6_pulses", pulses, 0);
      chk("t6_count", match_count, 0);

      // Length 12 clamps to 8
      load(8'hFF, 4'd12, 1'b1);
      pulses = 0;
      repeat (7) step(1'b1, 1'b1);
      chk("t7_pulses_7", pulses, 0);
      step(1'b1, 1'b1);
      chk("t7_out_8", out, 1);
      step(1'b0, 1'b0);
      chk("t7_pulses_8", pulses, 1);
      chk("t7_count", match_count, 1);

      step(1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
